// File: rtl/loader_pkg.sv
// Shared types and 8N1 frame constants for the UART parameter loader.
package loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck,
    StDone
  } loader_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  localparam int unsigned FrameDataBits = 8;
  localparam logic        FrameStartLvl = 1'b0;
  localparam logic        FrameStopLvl  = 1'b1;

  // Ceiling log2, never below 1 so it can size a register directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_sym_rx.sv
// 8N1 UART receiver that emits the low SYM_W data bits of each good frame as one symbol.
module uart_sym_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned SYM_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rx,
  output logic [SYM_W-1:0] o_sym,
  output logic             o_sym_valid,
  output logic             o_frame_err
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = clog2(ClksPerBit + 1);
  localparam int unsigned BitIdxW    = clog2(FrameDataBits);

  localparam logic [CntW-1:0]    BitEnd   = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]    HalfEnd  = CntW'(ClksPerBit / 2 - 1);
  localparam logic [BitIdxW-1:0] LastBit  = BitIdxW'(FrameDataBits - 1);

  rx_state_e                r_state, w_state_d;
  logic [CntW-1:0]          r_clk_cnt, w_clk_cnt_d;
  logic [BitIdxW-1:0]       r_bit_idx, w_bit_idx_d;
  logic [FrameDataBits-1:0] r_shift, w_shift_d;
  logic [SYM_W-1:0]         r_sym, w_sym_d;
  logic                     r_sym_valid, w_sym_valid_d;
  logic                     r_frame_err, w_frame_err_d;
  logic                     r_rx_meta, r_rx_sync, r_rx_prev;

  // Two-flop synchroniser plus one history stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RxIdle;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_clk_cnt   <= w_clk_cnt_d;
      r_bit_idx   <= w_bit_idx_d;
      r_shift     <= w_shift_d;
      r_sym       <= w_sym_d;
      r_sym_valid <= w_sym_valid_d;
      r_frame_err <= w_frame_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_clk_cnt_d   = r_clk_cnt;
    w_bit_idx_d   = r_bit_idx;
    w_shift_d     = r_shift;
    w_sym_d       = r_sym;
    w_sym_valid_d = 1'b0;
    w_frame_err_d = 1'b0;
    case (r_state)
      RxIdle: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_state_d   = RxStart;
          w_clk_cnt_d = '0;
        end
      end
      RxStart: begin
        if (r_clk_cnt == HalfEnd) begin
          w_clk_cnt_d = '0;
          // A start bit that is high again at mid-bit was a glitch.
          if (r_rx_sync == FrameStartLvl) begin
            w_state_d   = RxData;
            w_bit_idx_d = '0;
          end else begin
            w_state_d = RxIdle;
          end
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      RxData: begin
        if (r_clk_cnt == BitEnd) begin
          w_clk_cnt_d = '0;
          w_shift_d   = {r_rx_sync, r_shift[FrameDataBits-1:1]};
          if (r_bit_idx == LastBit) begin
            w_state_d = RxStop;
          end else begin
            w_bit_idx_d = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      RxStop: begin
        if (r_clk_cnt == BitEnd) begin
          w_clk_cnt_d = '0;
          w_state_d   = RxIdle;
          if (r_rx_sync == FrameStopLvl) begin
            w_sym_valid_d = 1'b1;
            w_sym_d       = r_shift[SYM_W-1:0];
          end else begin
            w_frame_err_d = 1'b1;
          end
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      default: w_state_d = RxIdle;
    endcase
  end

  assign o_sym       = r_sym;
  assign o_sym_valid = r_sym_valid;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_param_loader.sv
// Loads coef/bias/img parameter images over UART and commits them atomically.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum symbol before commit.
module uart_param_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned SYM_W     = 4,
  parameter int unsigned COEF_BITS = 138880,
  parameter int unsigned BIAS_BITS = 432,
  parameter int unsigned IMG_BITS  = 3136
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  input  logic                 reload_i,
  output logic [COEF_BITS-1:0] coef_o,
  output logic [BIAS_BITS-1:0] bias_o,
  output logic [IMG_BITS-1:0]  img_o,
  output logic                 start_o,
  output logic                 loaded_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned TotBits = COEF_BITS + BIAS_BITS + IMG_BITS;
  localparam int unsigned NSym    = TotBits / SYM_W;
  localparam int unsigned CntW    = clog2(NSym + 1);

  localparam logic [CntW-1:0] LastIdx = CntW'(NSym - 1);

  logic [SYM_W-1:0] w_sym;
  logic             w_sym_valid;
  logic             w_frame_err;

  uart_sym_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .SYM_W    (SYM_W)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (rx_i),
    .o_sym       (w_sym),
    .o_sym_valid (w_sym_valid),
    .o_frame_err (w_frame_err)
  );

  loader_state_e        r_state, w_state_d;
  logic [CntW-1:0]      r_cnt;
  logic [TotBits-1:0]   r_stage;
  logic [COEF_BITS-1:0] r_coef;
  logic [BIAS_BITS-1:0] r_bias;
  logic [IMG_BITS-1:0]  r_img;
  logic                 r_start;
  logic                 r_loaded;
  logic                 r_err;
  logic                 w_store;
  logic                 w_commit;
  logic                 w_ck_fail;

`ifdef LOADER_CHECKSUM_EN
  logic [SYM_W-1:0] r_xor;
`endif

  always_comb begin
    w_state_d = r_state;
    w_store   = 1'b0;
    w_commit  = 1'b0;
    w_ck_fail = 1'b0;
    // Reload has priority, so a coincident symbol strobe is dropped.
    if (reload_i) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_sym_valid) begin
            w_store   = 1'b1;
            w_state_d = (NSym == 1) ? StCheck : StLoad;
          end
        end
        StLoad: begin
          if (w_sym_valid) begin
            w_store = 1'b1;
            if (r_cnt == LastIdx) begin
              w_state_d = StCheck;
            end
          end
        end
        StCheck: begin
`ifdef LOADER_CHECKSUM_EN
          if (w_sym_valid) begin
            if (w_sym == r_xor) begin
              w_commit  = 1'b1;
              w_state_d = StDone;
            end else begin
              w_ck_fail = 1'b1;
              w_state_d = StIdle;
            end
          end
`else
          w_commit  = 1'b1;
          w_state_d = StDone;
`endif
        end
        StDone: begin
          w_state_d = StDone;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (reload_i || w_ck_fail) begin
      r_cnt <= '0;
    end else if (w_store) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xor <= '0;
    end else if (reload_i || w_ck_fail) begin
      r_xor <= '0;
    end else if (w_store) begin
      r_xor <= r_xor ^ w_sym;
    end
  end
`endif

  // Staging needs no reset: every slot is rewritten before a commit can happen.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_stage[r_cnt*SYM_W +: SYM_W] <= w_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_coef   <= '0;
      r_bias   <= '0;
      r_img    <= '0;
      r_start  <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_start <= w_commit;
      if (w_commit) begin
        r_coef   <= r_stage[0 +: COEF_BITS];
        r_bias   <= r_stage[COEF_BITS +: BIAS_BITS];
        r_img    <= r_stage[COEF_BITS+BIAS_BITS +: IMG_BITS];
        r_loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (reload_i) begin
      r_err <= 1'b0;
    end else if (w_frame_err || w_ck_fail) begin
      r_err <= 1'b1;
    end
  end

  assign coef_o   = r_coef;
  assign bias_o   = r_bias;
  assign img_o    = r_img;
  assign start_o  = r_start;
  assign loaded_o = r_loaded;
  assign busy_o   = (r_state == StLoad) || (r_state == StCheck);
  assign err_o    = r_err;

endmodule
